// File: rtl/mseq_frame_ctrl_if.sv
// mseq_frame_ctrl_if
//   Bundles the two buses of the frame sequencer:
//     - configuration handshake : cfg_valid / cfg_ready with cfg_fase, cfg_type, cfg_len
//     - generator link          : gen_step / gen_fase_new in, fase_out / type_out back
//   master : the side that offers configuration and owns the generator (bench / system)
//   slave  : mseq_frame_ctrl
interface mseq_frame_ctrl_if #(
  parameter int FASE_W = 4,
  parameter int LEN_W  = 6
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [FASE_W-1:0] cfg_fase;
  logic [FASE_W-1:0] cfg_type;
  logic [LEN_W-1:0]  cfg_len;
  logic              gen_step;
  logic [FASE_W-1:0] gen_fase_new;
  logic [FASE_W-1:0] fase_out;
  logic [FASE_W-1:0] type_out;

  modport master (
    output cfg_valid, cfg_fase, cfg_type, cfg_len, gen_step, gen_fase_new,
    input  cfg_ready, fase_out, type_out
  );

  modport slave (
    input  cfg_valid, cfg_fase, cfg_type, cfg_len, gen_step, gen_fase_new,
    output cfg_ready, fase_out, type_out
  );
endinterface

// File: rtl/mseq_frame_ctrl.sv
// mseq_frame_ctrl
//   Frame sequencer for the m-sequence generator. Owns the generator phase and
//   polynomial type, advances the phase on every generator strobe and wraps it
//   back to the seed after a programmable number of steps. New configuration
//   (seed, type, length) is taken through a valid/ready handshake into a shadow
//   and only applied at a frame boundary (IDLE, LOAD or the wrap step).
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   start, stop   : single-cycle pulses; stop finishes the current frame first
//   bus (slave)   : cfg_valid/cfg_ready/cfg_fase/cfg_type/cfg_len handshake,
//                   gen_step/gen_fase_new in, fase_out/type_out out
//   busy          : high in LOAD and RUN
//   frame_start   : pulse on the first step of a frame
//   frame_done    : pulse on the wrap step
//   step_cnt      : steps taken in the current frame
//   frame_cnt     : completed frames (wraps)
//   cfg_err       : sticky zero-seed flag
//
// Build option
//   MSEQ_FRAME_CTRL_SEED_CHECK_EN : when defined, an applied zero seed (LFSR
//   lock-up) is replaced by DEF_FASE and cfg_err is set until reset. When not
//   defined, a zero seed is applied as given and cfg_err stays 0.
module mseq_frame_ctrl #(
  parameter int                FASE_W   = 4,
  parameter int                LEN_W    = 6,
  parameter logic [FASE_W-1:0] DEF_FASE = 4'b0101,
  parameter logic [FASE_W-1:0] DEF_TYPE = 4'b1101,
  parameter int                DEF_LEN  = 32,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  mseq_frame_ctrl_if.slave     bus,
  output logic                 busy,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic [LEN_W-1:0]     step_cnt,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // Length is held as (len-1) so the wrap test is a plain compare; cfg_len==0
  // becomes all-ones, i.e. 2^LEN_W steps, without any special case.
  function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] l);
    return l - LEN_W'(1);
  endfunction

  state_t            state_q;
  logic [FASE_W-1:0] fase_q, seed_q, type_q;
  logic [LEN_W-1:0]  lenm1_q, step_q;
  logic [CNT_W-1:0]  frame_q;
  logic              shd_vld_q, stop_pend_q, busy_q, fstart_q, fdone_q, err_q;

  // Shadow payload carries no reset; shd_vld_q qualifies it.
  logic [FASE_W-1:0] shd_fase_q, shd_type_q;
  logic [LEN_W-1:0]  shd_lenm1_q;

  // Configuration that becomes active at the next boundary: the shadow if one
  // is pending, otherwise the current active set.
  logic [FASE_W-1:0] nxt_seed_d, nxt_type_d;
  logic [LEN_W-1:0]  nxt_lenm1_d;
  logic              nxt_err_d, nxt_bad;

  logic cfg_xfer;
  assign cfg_xfer = bus.cfg_valid && !shd_vld_q;

  always_comb begin
`ifdef MSEQ_FRAME_CTRL_SEED_CHECK_EN
    nxt_bad = shd_vld_q && (shd_fase_q == '0);
`else
    nxt_bad = 1'b0;
`endif
    nxt_seed_d  = seed_q;
    nxt_type_d  = type_q;
    nxt_lenm1_d = lenm1_q;
    nxt_err_d   = err_q | nxt_bad;
    if (shd_vld_q) begin
      nxt_seed_d  = nxt_bad ? DEF_FASE : shd_fase_q;
      nxt_type_d  = shd_type_q;
      nxt_lenm1_d = shd_lenm1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_xfer) begin
      shd_fase_q  <= bus.cfg_fase;
      shd_type_q  <= bus.cfg_type;
      shd_lenm1_q <= len_m1(bus.cfg_len);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fase_q      <= DEF_FASE;
      seed_q      <= DEF_FASE;
      type_q      <= DEF_TYPE;
      lenm1_q     <= LEN_W'(DEF_LEN - 1);
      step_q      <= '0;
      frame_q     <= '0;
      shd_vld_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      fstart_q    <= 1'b0;
      fdone_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fstart_q <= 1'b0;
      fdone_q  <= 1'b0;
      if (cfg_xfer) shd_vld_q <= 1'b1;

      case (state_q)
        IDLE: begin
          // A pending shadow is applied straight away while idle.
          seed_q  <= nxt_seed_d;
          type_q  <= nxt_type_d;
          lenm1_q <= nxt_lenm1_d;
          err_q   <= nxt_err_d;
          fase_q  <= nxt_seed_d;
          if (shd_vld_q) shd_vld_q <= 1'b0;
          if (start && !stop) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end

        LOAD: begin
          // gen_step in this cycle is deliberately not counted.
          seed_q  <= nxt_seed_d;
          type_q  <= nxt_type_d;
          lenm1_q <= nxt_lenm1_d;
          err_q   <= nxt_err_d;
          fase_q  <= nxt_seed_d;
          if (shd_vld_q) shd_vld_q <= 1'b0;
          step_q  <= '0;
          state_q <= RUN;
        end

        RUN: begin
          if (bus.gen_step) begin
            fstart_q <= (step_q == '0);
            if (step_q != lenm1_q) begin
              step_q      <= step_q + LEN_W'(1);
              fase_q      <= bus.gen_fase_new;
              stop_pend_q <= stop_pend_q | stop;
            end else begin
              // Wrap: new config lands on this same edge so the next frame
              // starts cleanly from the new seed and type.
              step_q  <= '0;
              seed_q  <= nxt_seed_d;
              type_q  <= nxt_type_d;
              lenm1_q <= nxt_lenm1_d;
              err_q   <= nxt_err_d;
              fase_q  <= nxt_seed_d;
              if (shd_vld_q) shd_vld_q <= 1'b0;
              fdone_q <= 1'b1;
              frame_q <= frame_q + CNT_W'(1);
              if (stop_pend_q) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                stop_pend_q <= 1'b0;
              end else begin
                stop_pend_q <= stop;
              end
            end
          end else begin
            stop_pend_q <= stop_pend_q | stop;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = ~shd_vld_q;
  assign bus.fase_out  = fase_q;
  assign bus.type_out  = type_q;
  assign busy          = busy_q;
  assign frame_start   = fstart_q;
  assign frame_done    = fdone_q;
  assign step_cnt      = step_q;
  assign frame_cnt     = frame_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_mseq_frame_ctrl.sv
// Testbench for mseq_frame_ctrl: directed scenarios plus a randomized run
// checked against an integer-level reference model of the frame rules.
module tb_mseq_frame_ctrl;

`ifdef MSEQ_FRAME_CTRL_SEED_CHECK_EN
  localparam bit SEED_CHK = 1'b1;
`else
  localparam bit SEED_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop;
  logic        busy, frame_start, frame_done, cfg_err;
  logic [5:0]  step_cnt;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  mseq_frame_ctrl_if #(.FASE_W(4), .LEN_W(6)) bus ();

  mseq_frame_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .bus         (bus),
    .busy        (busy),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .step_cnt    (step_cnt),
    .frame_cnt   (frame_cnt),
    .cfg_err     (cfg_err)
  );

  always #10 clk = ~clk;

  // ---------------- reference model (plain integers) ----------------
  int m_mode;               // 0 idle, 1 load, 2 run
  int m_seed, m_fase, m_type, m_len, m_pos, m_frames;
  bit m_pend, m_err, m_fs, m_fd, m_shd;
  int s_fase, s_type, s_len;

  function automatic void model_reset();
    m_mode = 0; m_seed = 5; m_fase = 5; m_type = 13; m_len = 32;
    m_pos = 0; m_frames = 0; m_pend = 0; m_err = 0; m_fs = 0; m_fd = 0; m_shd = 0;
  endfunction

  function automatic void model_apply();
    if (SEED_CHK && s_fase == 0) begin m_seed = 5; m_err = 1; end
    else m_seed = s_fase;
    m_type = s_type;
    m_len  = (s_len == 0) ? 64 : s_len;
    m_shd  = 0;
  endfunction

  function automatic void model_edge();
    bit shd_old = m_shd;
    m_fs = 0; m_fd = 0;
    case (m_mode)
      0: begin
        if (m_shd) begin model_apply(); m_fase = m_seed; end
        if (start && !stop) m_mode = 1;
      end
      1: begin
        if (m_shd) model_apply();
        m_fase = m_seed; m_pos = 0; m_mode = 2;
      end
      default: begin
        if (bus.gen_step) begin
          m_fs = (m_pos == 0);
          if (m_pos < m_len - 1) begin
            m_pos++; m_fase = int'(bus.gen_fase_new); m_pend |= stop;
          end else begin
            m_pos = 0;
            if (m_shd) model_apply();
            m_fase = m_seed; m_fd = 1; m_frames = (m_frames + 1) % 65536;
            if (m_pend) begin m_mode = 0; m_pend = 0; end
            else m_pend = stop;
          end
        end else m_pend |= stop;
      end
    endcase
    if (bus.cfg_valid && !shd_old) begin
      m_shd = 1; s_fase = int'(bus.cfg_fase); s_type = int'(bus.cfg_type); s_len = int'(bus.cfg_len);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic strobe(input logic [3:0] v);
    bus.gen_step = 1'b1; bus.gen_fase_new = v;
    tick();
    bus.gen_step = 1'b0;
  endtask

  task automatic offer_cfg(input logic [3:0] f, input logic [3:0] t, input logic [5:0] l);
    bus.cfg_valid = 1'b1; bus.cfg_fase = f; bus.cfg_type = t; bus.cfg_len = l;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0;
    bus.cfg_valid = 0; bus.cfg_fase = 0; bus.cfg_type = 0; bus.cfg_len = 0;
    bus.gen_step = 0; bus.gen_fase_new = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.fase_out !== 4'b0101) begin n_err++; $display("FAIL reset_fase got %h want 5", bus.fase_out); end
    n_vec++; if (bus.type_out !== 4'b1101) begin n_err++; $display("FAIL reset_type got %h want d", bus.type_out); end
    n_vec++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.cfg_ready); end
    n_vec++; if (busy !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0 || cfg_err !== 1'b0)
      begin n_err++; $display("FAIL reset_flags got %b%b%b%b want 0000", busy, frame_start, frame_done, cfg_err); end
    n_vec++; if (step_cnt !== 6'd0 || frame_cnt !== 16'd0)
      begin n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", step_cnt, frame_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    start = 1'b1; tick(); start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy got %b want 1", busy); end
    tick();
    n_vec++; if (bus.fase_out !== 4'd5 || step_cnt !== 6'd0)
      begin n_err++; $display("FAIL run_entry got %h/%0d want 5/0", bus.fase_out, step_cnt); end
    for (int i = 1; i <= 32; i++) begin
      strobe(4'(i));
      if (i < 32) begin
        n_vec++; if (bus.fase_out !== 4'(i) || step_cnt !== 6'(i))
          begin n_err++; $display("FAIL basic_step%0d got %h/%0d want %h/%0d", i, bus.fase_out, step_cnt, 4'(i), i); end
      end else begin
        n_vec++; if (bus.fase_out !== 4'd5 || step_cnt !== 6'd0 || frame_cnt !== 16'd1)
          begin n_err++; $display("FAIL basic_wrap got %h/%0d/%0d want 5/0/1", bus.fase_out, step_cnt, frame_cnt); end
      end
      n_vec++; if (frame_done !== (i == 32) || frame_start !== (i == 1))
        begin n_err++; $display("FAIL basic_pulses%0d got %b%b want %b%b", i, frame_start, frame_done, i == 1, i == 32); end
    end
  endtask

  task automatic test_cfg_in_run();
    logic [3:0] v;
    for (int i = 1; i <= 10; i++) begin
      v = 4'($urandom); strobe(v);
      n_vec++; if (bus.fase_out !== v) begin n_err++; $display("FAIL cfgrun_pre%0d got %h want %h", i, bus.fase_out, v); end
    end
    n_vec++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL cfgrun_ready_before got %b want 1", bus.cfg_ready); end
    offer_cfg(4'b0011, 4'b1001, 6'd5);
    n_vec++; if (bus.cfg_ready !== 1'b0 || bus.type_out !== 4'b1101)
      begin n_err++; $display("FAIL cfgrun_latched got %b/%h want 0/d", bus.cfg_ready, bus.type_out); end
    for (int i = 11; i <= 32; i++) begin
      v = 4'($urandom); strobe(v);
      if (i < 32) begin
        n_vec++; if (bus.cfg_ready !== 1'b0 || bus.fase_out !== v)
          begin n_err++; $display("FAIL cfgrun_hold%0d got %b/%h want 0/%h", i, bus.cfg_ready, bus.fase_out, v); end
      end else begin
        n_vec++; if (bus.fase_out !== 4'b0011 || bus.type_out !== 4'b1001 || frame_done !== 1'b1 || frame_cnt !== 16'd2)
          begin n_err++; $display("FAIL cfgrun_wrap got %h/%h/%b/%0d want 3/9/1/2", bus.fase_out, bus.type_out, frame_done, frame_cnt); end
        n_vec++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL cfgrun_ready_after got %b want 1", bus.cfg_ready); end
      end
    end
    for (int k = 1; k <= 5; k++) begin
      strobe(4'($urandom));
      n_vec++; if (frame_done !== (k == 5)) begin n_err++; $display("FAIL len5_done%0d got %b want %b", k, frame_done, k == 5); end
    end
    n_vec++; if (bus.fase_out !== 4'b0011 || frame_cnt !== 16'd3)
      begin n_err++; $display("FAIL len5_wrap got %h/%0d want 3/3", bus.fase_out, frame_cnt); end
  endtask

  task automatic test_stop();
    repeat (3) strobe(4'($urandom));
    stop = 1'b1; tick(); stop = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL stop_still_busy got %b want 1", busy); end
    strobe(4'hE);
    n_vec++; if (busy !== 1'b1 || frame_done !== 1'b0)
      begin n_err++; $display("FAIL stop_step4 got %b/%b want 1/0", busy, frame_done); end
    strobe(4'hE);
    n_vec++; if (busy !== 1'b0 || frame_done !== 1'b1 || bus.fase_out !== 4'b0011 || frame_cnt !== 16'd4)
      begin n_err++; $display("FAIL stop_wrap got %b/%b/%h/%0d want 0/1/3/4", busy, frame_done, bus.fase_out, frame_cnt); end
    repeat (2) strobe(4'h9);
    n_vec++; if (bus.fase_out !== 4'b0011 || step_cnt !== 6'd0 || frame_done !== 1'b0)
      begin n_err++; $display("FAIL idle_ignores_step got %h/%0d/%b want 3/0/0", bus.fase_out, step_cnt, frame_done); end
  endtask

  task automatic test_len_extremes();
    offer_cfg(4'd7, 4'd2, 6'd0);
    n_vec++; if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL idle_cfg_ready_low got %b want 0", bus.cfg_ready); end
    tick();
    n_vec++; if (bus.cfg_ready !== 1'b1 || bus.fase_out !== 4'd7 || bus.type_out !== 4'd2)
      begin n_err++; $display("FAIL idle_cfg_apply got %b/%h/%h want 1/7/2", bus.cfg_ready, bus.fase_out, bus.type_out); end
    start = 1'b1; tick(); start = 1'b0;
    bus.gen_step = 1'b1; tick(); bus.gen_step = 1'b0;   // strobe during LOAD is dropped
    n_vec++; if (step_cnt !== 6'd0) begin n_err++; $display("FAIL load_drop got %0d want 0", step_cnt); end
    for (int i = 1; i <= 64; i++) begin
      if (i == 10) stop = 1'b1;
      strobe(4'($urandom));
      stop = 1'b0;
      n_vec++; if (frame_done !== (i == 64)) begin n_err++; $display("FAIL len64_done%0d got %b want %b", i, frame_done, i == 64); end
    end
    n_vec++; if (busy !== 1'b0 || frame_cnt !== 16'd5 || bus.fase_out !== 4'd7)
      begin n_err++; $display("FAIL len64_end got %b/%0d/%h want 0/5/7", busy, frame_cnt, bus.fase_out); end
    offer_cfg(4'hA, 4'hC, 6'd1);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      strobe(4'($urandom));
      n_vec++; if (frame_start !== 1'b1 || frame_done !== 1'b1 || frame_cnt !== 16'(5 + i) || bus.fase_out !== 4'hA)
        begin n_err++; $display("FAIL len1_%0d got %b%b/%0d/%h want 11/%0d/a", i, frame_start, frame_done, frame_cnt, bus.fase_out, 5 + i); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (17) strobe(4'($urandom));
    n_vec++; if (step_cnt !== 6'd17) begin n_err++; $display("FAIL pre_reset_step got %0d want 17", step_cnt); end
    #3 rst = 1'b1;
    #1;
    n_vec++; if (bus.fase_out !== 4'd5 || bus.type_out !== 4'hD || step_cnt !== 6'd0 || frame_cnt !== 16'd0)
      begin n_err++; $display("FAIL async_reset_vals got %h/%h/%0d/%0d want 5/d/0/0", bus.fase_out, bus.type_out, step_cnt, frame_cnt); end
    n_vec++; if (busy !== 1'b0 || frame_done !== 1'b0 || bus.cfg_ready !== 1'b1)
      begin n_err++; $display("FAIL async_reset_ctl got %b/%b/%b want 0/0/1", busy, frame_done, bus.cfg_ready); end
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_seed_check();
    offer_cfg(4'd0, 4'd9, 6'd7);
    tick();
    n_vec++; if (bus.fase_out !== (SEED_CHK ? 4'd5 : 4'd0) || cfg_err !== SEED_CHK || bus.type_out !== 4'd9)
      begin n_err++; $display("FAIL zero_seed got %h/%b/%h want %h/%b/9", bus.fase_out, cfg_err, bus.type_out, SEED_CHK ? 4'd5 : 4'd0, SEED_CHK); end
    offer_cfg(4'd6, 4'd3, 6'd4);
    tick();
    n_vec++; if (bus.fase_out !== 4'd6 || cfg_err !== SEED_CHK)
      begin n_err++; $display("FAIL err_sticky got %h/%b want 6/%b", bus.fase_out, cfg_err, SEED_CHK); end
  endtask

  task automatic test_random();
    logic [34:0] act_v, exp_v;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      start            = ($urandom % 16) == 0;
      stop             = ($urandom % 64) == 0;
      bus.cfg_valid    = ($urandom % 6) == 0;
      bus.cfg_fase     = 4'($urandom);
      bus.cfg_type     = 4'($urandom);
      bus.cfg_len      = 6'($urandom % 8);
      bus.gen_step     = ($urandom % 10) < 6;
      bus.gen_fase_new = 4'($urandom);
      tick();
      act_v = {bus.fase_out, bus.type_out, bus.cfg_ready, busy, frame_start, frame_done, step_cnt, frame_cnt, cfg_err};
      exp_v = {4'(m_fase), 4'(m_type), ~m_shd, (m_mode != 0), m_fs, m_fd, 6'(m_pos), 16'(m_frames), m_err};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL random_cyc%0d got %h want %h", c, act_v, exp_v);
      end
    end
    start = 0; stop = 0; bus.cfg_valid = 0; bus.gen_step = 0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_cfg_in_run();
    test_stop();
    test_len_extremes();
    test_reset_mid();
    test_seed_check();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mseq_frame_ctrl.md
Name: mseq_frame_ctrl

Overview:
- Sequencer for the m-sequence generator (mfun) and its serial decoder.
- Owns the generator's phase register and polynomial type.
- Steps the phase once per generator control strobe and wraps it back to the seed after a programmable frame length.
- Accepts runtime reconfiguration (seed, type, length) through a valid/ready handshake, applied only at frame boundaries so frames are never torn.

Parameters:
- FASE_W, 4, width of phase/seed and type words
- LEN_W, 6, width of frame-length field
- DEF_FASE, 4'b0101, seed loaded on reset
- DEF_TYPE, 4'b1101, polynomial type loaded on reset
- DEF_LEN, 32, frame length in steps loaded on reset
- CNT_W, 16, width of frame counter

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: begin framing
- stop  in  1  single-cycle pulse: finish current frame, then idle
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  configuration shadow free
- cfg_fase  in  FASE_W  seed
- cfg_type  in  FASE_W  polynomial type
- cfg_len  in  LEN_W  steps per frame; 0 means 2^LEN_W
- gen_step  in  1  generator control strobe, one clk wide
- gen_fase_new  in  FASE_W  next phase from generator
- fase_out  out  FASE_W  phase driven to generator
- type_out  out  FASE_W  type driven to generator
- busy  out  1  high in LOAD/RUN
- frame_start  out  1  one-cycle pulse on first step of each frame
- frame_done  out  1  one-cycle pulse on wrap step
- step_cnt  out  LEN_W  steps taken in current frame
- frame_cnt  out  CNT_W  completed frames, wraps at 2^CNT_W
- cfg_err  out  1  sticky, see Optional Feature

Behaviour:
- Reset values (async, all outputs):
  - fase_out=DEF_FASE, type_out=DEF_TYPE, active length=DEF_LEN
  - step_cnt=0, frame_cnt=0, busy=0, pulses=0, cfg_ready=1, cfg_err=0, state=IDLE, stop-pending cleared
- Reset mid-frame aborts immediately; no frame_done is emitted.
- States:
  - IDLE: fase_out held at active seed; gen_step ignored. start -> LOAD. If start and stop arrive in the same cycle, stop wins and the block stays IDLE.
  - LOAD (1 cycle): apply pending shadow config if present; fase_out<=seed; step_cnt<=0 -> RUN.
  - RUN, on gen_step:
    - If step_cnt==0, pulse frame_start in the same cycle as the count update.
    - If step_cnt != len-1: step_cnt+1, fase_out<=gen_fase_new.
    - Else (wrap): step_cnt<=0, fase_out<=seed (pending config applied first, so new seed/type take effect on this exact edge), frame_done pulse, frame_cnt+1. If stop is pending -> IDLE, else remain RUN.
  - RUN, without gen_step: all outputs hold.
- stop in RUN sets stop-pending; it takes effect at the next wrap. stop in IDLE/LOAD is ignored.
- cfg handshake:
  - Transfer occurs when cfg_valid && cfg_ready; the shadow latches and cfg_ready drops on the next edge.
  - In IDLE the shadow is applied on the following cycle and cfg_ready re-asserts 1 cycle later.
  - In RUN the shadow is applied at wrap; cfg_ready re-asserts the cycle after wrap.
  - cfg_valid held without ready has no effect.
- Length: len = (cfg_len==0) ? 2^LEN_W : cfg_len. With len=1 every gen_step is a wrap, so frame_start and frame_done pulse together.
- gen_step coinciding with the LOAD cycle is dropped; the first counted step is the first strobe seen in RUN.

Optional Feature:
- Macro: MSEQ_FRAME_CTRL_SEED_CHECK_EN.
- Enabled: an accepted config with cfg_fase==0 (LFSR lock-up seed) has its seed replaced by DEF_FASE when applied; cfg_err sets and stays set until rst. Type and length are applied normally.
- Disabled: a zero seed is applied as given; cfg_err is tied 0.

Test Plan:
- Reset, then start, then 32 gen_step strobes with gen_fase_new=step index -> fase_out follows 1..31, then returns to 4'b0101 on strobe 32; frame_done pulses once; frame_cnt=1; step_cnt=0.
- In RUN at step 10, offer cfg fase=4'b0011, type=4'b1001, len=5 -> cfg_ready low until wrap at step 32; at wrap fase_out=4'b0011 and type_out=4'b1001; next frame_done after 5 strobes.
- stop pulsed at step 3 -> continues to step 32 wrap, frame_done pulses, busy=0, further gen_step leaves fase_out=seed.
- cfg_len=0 then start -> wrap only after 64 strobes; cfg_len=1 -> frame_start and frame_done coincide on every strobe.
- Assert rst at step 17 -> all outputs at reset values immediately (async); no frame_done; frame_cnt=0.
- With MSEQ_FRAME_CTRL_SEED_CHECK_EN: cfg fase=0 in IDLE -> fase_out=4'b0101, cfg_err=1. Without the macro -> fase_out=0, cfg_err=0.
